// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1-style asynchronous serial receiver driven by a 16x
//             oversampling tick. Synchronises rx, validates the start bit at
//             mid-bit, samples data bits LSB first at bit centres, checks the
//             stop bit and presents each byte through a valid/ack register.
//  Ports    : clock, reset          - clock and synchronous active-high reset
//             uart_tick_16x         - one-clock pulse at 16x baud
//             rx                    - asynchronous serial line, idle high
//             data / data_valid     - received byte and its unconsumed flag
//             data_ack              - consumer accepts data (while valid)
//             framing_error         - one-clock pulse, stop bit sampled 0
//             overrun               - one-clock pulse, completed byte dropped
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 uart_tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] c_LAST_BIT = BCW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_next;
  logic [BCW-1:0]       r_bitcnt;
  logic [BCW-1:0]       w_bitcnt_next;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_shift_en;
  logic                 w_frame_done;
  logic                 w_stop_bad;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_ovr;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // State register plus the tick-driven counters and shift register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_bitcnt <= w_bitcnt_next;
      // Right shift: the first bit on the wire ends up in bit 0.
      if (w_shift_en) begin
        r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
      end
    end
  end

  // Next-state logic. Nothing advances on non-tick clocks.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_bitcnt_next = r_bitcnt;
    w_shift_en    = 1'b0;
    w_frame_done  = 1'b0;
    w_stop_bad    = 1'b0;
    if (uart_tick_16x) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            w_cnt_next   = 4'd0;
            w_state_next = S_START;
          end
        end
        S_START: begin
          w_cnt_next = r_cnt + 4'd1;
          // Half a bit after the falling edge: confirm a real start bit.
          if (r_cnt == 4'd7) begin
            if (!r_rx_s) begin
              w_state_next  = S_DATA;
              w_cnt_next    = 4'd0;
              w_bitcnt_next = '0;
            end else begin
              w_state_next = S_IDLE;
            end
          end
        end
        S_DATA: begin
          w_cnt_next = r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            w_shift_en = 1'b1;
            if (r_bitcnt == c_LAST_BIT) begin
              w_state_next = S_STOP;
              w_cnt_next   = 4'd0;
            end else begin
              w_bitcnt_next = r_bitcnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          w_cnt_next = r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            if (r_rx_s) begin
              w_frame_done = 1'b1;
              w_state_next = S_IDLE;
            end else begin
              w_stop_bad   = 1'b1;
              w_state_next = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // A held-low line must return high before a new start is looked for.
          if (r_rx_s) begin
            w_state_next = S_IDLE;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // Output handshake register. A frame completing in the same clock as an
  // ack replaces the consumed byte without dropping valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_stop_bad;
      r_ovr  <= 1'b0;
      if (w_frame_done) begin
        if (!r_valid || data_ack) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && data_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data          = r_data;
  assign data_valid    = r_valid;
  assign framing_error = r_ferr;
  assign overrun       = r_ovr;

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1-style asynchronous serial receiver, the consumer of the 16x oversampling tick from the UART baud generator. Synchronises the rx line, validates the start bit at mid-bit, and samples data bits LSB first at bit centres. Checks the stop bit and presents each received byte through a valid/ack output register. Reports framing and overrun errors.

Parameters:
DATA_BITS, 8, data bits per frame (legal 5..8); no parity; one stop bit.

Ports:
clock  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
uart_tick_16x  input  1  one-clock pulse at 16x baud, from the baud generator.
rx  input  1  asynchronous serial line, idle high.
data  output  DATA_BITS  received byte, LSB = first bit on the wire.
data_valid  output  1  data holds an unconsumed byte.
data_ack  input  1  consumer accepts data; honoured only while data_valid=1.
framing_error  output  1  one-clock pulse when the stop bit samples 0.
overrun  output  1  one-clock pulse when a completed byte is dropped.

Behaviour:
- Reset: state=IDLE, tick counter=0, bit counter=0, shift reg=0, both rx synchroniser flops=1; data=0, data_valid=0, framing_error=0, overrun=0. Reset mid-frame abandons the frame with no error pulse.
- rx passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s and occurs only on clocks where uart_tick_16x=1. Non-tick clocks change no state except the output handshake.
- 4-bit tick counter cnt wraps 15->0.
- IDLE: on a tick with rx_s=0, cnt<=0 and go to START.
- START: on each tick, cnt<=cnt+1. On the 8th tick after the detect tick (cnt==7 before the increment), sample rx_s:
  - 0 -> go to DATA, cnt<=0, bit counter<=0.
  - 1 -> glitch; go to IDLE with no output.
- DATA: on each tick, cnt<=cnt+1. On the 16th tick after the previous sample (cnt==15), shift rx_s in at the MSB end (right shift), so the first bit lands in bit 0 after DATA_BITS shifts. After DATA_BITS samples, go to STOP, cnt<=0.
- STOP: on the 16th tick, sample rx_s:
  - 1 -> frame complete; go to IDLE.
  - 0 -> framing_error=1 for exactly one clock, byte discarded, go to BREAK.
- BREAK: wait for a tick with rx_s=1, then go to IDLE. This prevents a held-low line from generating repeated frames.
- Output register:
  - Frame complete and data_valid=0: the next clock sets data<=shift reg and data_valid<=1.
  - data_ack=1 while data_valid=1: clears data_valid on the next clock. data keeps its last value.
  - Frame complete while data_valid=1 and data_ack=0: new byte dropped, old data unchanged, overrun=1 for one clock.
  - Frame complete in the same clock as data_ack with data_valid=1: new byte loaded, data_valid stays 1, no overrun.
  - data_ack while data_valid=0: ignored.
- Latency: data_valid rises 1 clock after the stop-sample tick clock. End to end, it rises 2 synchroniser clocks plus one clock after the line reaches stop-bit centre.
- The receiver never blocks on the consumer; reception continues regardless of data_valid.

Test Plan:
1. Bench drives uart_tick_16x every 36 clocks (bit = 576 clocks). Send 0xA5 8N1 -> data=0xA5, data_valid=1 until one data_ack, single assertion, no error pulses.
2. rx low for 4 ticks then high -> no data_valid, no framing_error, FSM back in IDLE. A following 0x3C frame -> data=0x3C.
3. Send 0x55 with stop bit 0, then hold rx low 3 bit times -> exactly one framing_error pulse, no data_valid, no new frame while low. After rx returns high, 0x81 -> data=0x81.
4. Send 0x11 then 0x22 back-to-back with no ack -> data stays 0x11, one overrun pulse. Repeat with data_ack timed to the 0x22 stop-sample clock -> data=0x22, data_valid stays 1, no overrun.
5. Assert reset for 1 clock during data bit 3 of a frame -> all outputs 0 next clock, no error pulses. A following 0xFF frame is received correctly.
6. Tolerance: transmit with bit period 16 ticks ±3% (tick spacing fixed, rx edges skewed), 0x5A and 0x00 -> both received correctly, no errors.
